// File: rtl/multiplier_taint_pkg.sv
// Shared types and elaboration helpers for the taint-tracked radix multiplier.
package multiplier_taint_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned MAX_WIDTH = 64;

    function automatic int unsigned cycles(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
        return unsigned'($clog2(cycles(width, bpc) + 1));
    endfunction

    // Result bit i is tainted if any operand taint bit at or below min(i, width-1) is set.
    function automatic logic [2*MAX_WIDTH-1:0] prefix_or_taint(
        input logic [MAX_WIDTH-1:0] a_t,
        input logic [MAX_WIDTH-1:0] b_t,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0]   m;
        logic                   run;
        logic [2*MAX_WIDTH-1:0] res;
        m   = a_t | b_t;
        run = 1'b0;
        res = '0;
        for (int unsigned i = 0; i < 2*MAX_WIDTH; i++) begin
            if (i < width) begin
                run = run | m[0];
            end
            m   = m >> 1;
            res = {run, res[2*MAX_WIDTH-1:1]};
        end
        return res;
    endfunction

endpackage

// File: rtl/multiplier_radix_control_taint.sv
// Sequencer for the radix multiplier: IDLE/RUN/DONE FSM, digit counter, busy/done and their taints.
module multiplier_radix_control_taint
    import multiplier_taint_pkg::*;
#(
    parameter int unsigned CYCLES = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic start_t,
    output logic accept_c,
    output logic run_c,
    output logic last_c,
    output logic cap_start_t,
    output logic busy,
    output logic busy_t,
    output logic done,
    output logic done_t
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_t_q, start_t_d;
    logic             busy_q, busy_d;
    logic             busy_t_q, busy_t_d;
    logic             done_q, done_d;
    logic             done_t_q, done_t_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            start_t_q <= 1'b0;
            busy_q    <= 1'b0;
            busy_t_q  <= 1'b0;
            done_q    <= 1'b0;
            done_t_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_t_q <= start_t_d;
            busy_q    <= busy_d;
            busy_t_q  <= busy_t_d;
            done_q    <= done_d;
            done_t_q  <= done_t_d;
        end
    end

    // start is only looked at in IDLE or DONE; RUN ignores it entirely.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_t_d = start_t_q;
        accept_c  = 1'b0;
        run_c     = 1'b0;
        last_c    = 1'b0;

        case (state_q)
            IDLE: begin
                accept_c = start;
            end
            RUN: begin
                run_c = 1'b1;
                if (cnt_q == '0) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                accept_c = start;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_c) begin
            state_d   = RUN;
            cnt_d     = CNT_W'(CYCLES - 1);
            start_t_d = start_t;
        end

        busy_d   = (state_d == RUN);
        done_d   = (state_d == DONE);
        busy_t_d = busy_d & start_t_d;
        done_t_d = done_d & start_t_d;
    end

    assign cap_start_t = start_t_q;
    assign busy        = busy_q;
    assign busy_t      = busy_t_q;
    assign done        = done_q;
    assign done_t      = done_t_q;

endmodule

// File: rtl/multiplier_radix_taint.sv
// Constant-time radix-2^BITS_PER_CYCLE shift-add multiplier, signed/unsigned, with conservative taint.
module multiplier_radix_taint
    import multiplier_taint_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 start_t,
    input  logic                 signed_mode,
    input  logic                 signed_mode_t,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplier_t,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplicand_t,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   product_t,
    output logic                 busy,
    output logic                 busy_t,
    output logic                 done,
    output logic                 done_t
);

    localparam int unsigned CYCLES = cycles(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CNT_W  = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned PW     = 2 * WIDTH;

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
        $error("multiplier_radix_taint: BITS_PER_CYCLE must be 1, 2 or 4");
    end
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_width
        $error("multiplier_radix_taint: WIDTH must be a multiple of BITS_PER_CYCLE");
    end
    if (WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_bad_range
        $error("multiplier_radix_taint: WIDTH must be in 1..MAX_WIDTH");
    end

    logic accept_c, run_c, last_c, cap_start_t;

    multiplier_radix_control_taint #(
        .CYCLES (CYCLES),
        .CNT_W  (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_t     (start_t),
        .accept_c    (accept_c),
        .run_c       (run_c),
        .last_c      (last_c),
        .cap_start_t (cap_start_t),
        .busy        (busy),
        .busy_t      (busy_t),
        .done        (done),
        .done_t      (done_t)
    );

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             signed_q, signed_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_t_q, mplier_t_d;
    logic [WIDTH-1:0] mcand_t_q, mcand_t_d;
    logic             smode_t_q, smode_t_d;
    logic [PW-1:0]    product_q, product_d;
    logic [PW-1:0]    product_t_q, product_t_d;

    logic [PW-1:0]             pp;
    logic [PW-1:0]             mc;
    logic [BITS_PER_CYCLE-1:0] dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            signed_q    <= 1'b0;
            acc_q       <= '0;
            mplier_t_q  <= '0;
            mcand_t_q   <= '0;
            smode_t_q   <= 1'b0;
            product_q   <= '0;
            product_t_q <= '0;
        end else begin
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            signed_q    <= signed_d;
            acc_q       <= acc_d;
            mplier_t_q  <= mplier_t_d;
            mcand_t_q   <= mcand_t_d;
            smode_t_q   <= smode_t_d;
            product_q   <= product_d;
            product_t_q <= product_t_d;
        end
    end

    // Digit partial product; the top bit of the final digit carries negative weight in signed mode.
    always_comb begin
        pp  = '0;
        mc  = mcand_q;
        dig = mplier_q[BITS_PER_CYCLE-1:0];
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            if (dig[0]) begin
                if (j == BITS_PER_CYCLE - 1 && last_c && signed_q) begin
                    pp = pp - mc;
                end else begin
                    pp = pp + mc;
                end
            end
            mc  = mc << 1;
            dig = dig >> 1;
        end
    end

    always_comb begin
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        signed_d    = signed_q;
        acc_d       = acc_q;
        mplier_t_d  = mplier_t_q;
        mcand_t_d   = mcand_t_q;
        smode_t_d   = smode_t_q;
        product_d   = product_q;
        product_t_d = product_t_q;

        if (accept_c) begin
            mcand_d    = {{WIDTH{multiplicand[WIDTH-1] & signed_mode}}, multiplicand};
            mplier_d   = multiplier;
            signed_d   = signed_mode;
            acc_d      = '0;
            mplier_t_d = multiplier_t;
            mcand_t_d  = multiplicand_t;
            smode_t_d  = signed_mode_t;
        end else if (run_c) begin
            acc_d    = acc_q + pp;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            if (last_c) begin
                product_d = acc_q + pp;
                if (smode_t_q || cap_start_t) begin
                    product_t_d = '1;
                end else begin
                    product_t_d = PW'(prefix_or_taint(MAX_WIDTH'(mplier_t_q),
                                                      MAX_WIDTH'(mcand_t_q), WIDTH));
                end
            end
        end
    end

    assign product   = product_q;
    assign product_t = product_t_q;

endmodule

// File: tb/tb_multiplier_radix_taint.sv
// Directed self-checking bench for multiplier_radix_taint at WIDTH=8 with radix 1, 2 and 4 instances.
module tb_multiplier_radix_taint;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, start_t = 1'b0;
    logic         signed_mode = 1'b0, signed_mode_t = 1'b0;
    logic [W-1:0] mplier = '0, mplier_t = '0, mcand = '0, mcand_t = '0;

    logic [2*W-1:0] p1, pt1, p2, pt2, p4, pt4;
    logic           busy1, busy_t1, done1, done_t1;
    logic           busy2, busy_t2, done2, done_t2;
    logic           busy4, busy_t4, done4, done_t4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiplier_radix_taint #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
        .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
        .multiplier(mplier), .multiplier_t(mplier_t),
        .multiplicand(mcand), .multiplicand_t(mcand_t),
        .product(p1), .product_t(pt1), .busy(busy1), .busy_t(busy_t1),
        .done(done1), .done_t(done_t1)
    );

    multiplier_radix_taint #(.WIDTH(W), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
        .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
        .multiplier(mplier), .multiplier_t(mplier_t),
        .multiplicand(mcand), .multiplicand_t(mcand_t),
        .product(p2), .product_t(pt2), .busy(busy2), .busy_t(busy_t2),
        .done(done2), .done_t(done_t2)
    );

    multiplier_radix_taint #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
        .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
        .multiplier(mplier), .multiplier_t(mplier_t),
        .multiplicand(mcand), .multiplicand_t(mcand_t),
        .product(p4), .product_t(pt4), .busy(busy4), .busy_t(busy_t4),
        .done(done4), .done_t(done_t4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic [W-1:0] at, input logic [W-1:0] bt,
                         input logic smt, input logic st);
        mplier        = a;
        mcand         = b;
        signed_mode   = sm;
        mplier_t      = at;
        mcand_t       = bt;
        signed_mode_t = smt;
        start_t       = st;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done2 && cyc < 12) begin
            step();
            cyc++;
        end
        if (!done2) check("done_timeout", 64'(done2), 64'd1);
    endtask

    initial begin
        logic saw_done;

        // Reset state
        step();
        step();
        check("rst_product",   64'(p2),      64'h0);
        check("rst_product_t", 64'(pt2),     64'h0);
        check("rst_busy",      64'(busy2),   64'h0);
        check("rst_busy_t",    64'(busy_t2), 64'h0);
        check("rst_done",      64'(done2),   64'h0);
        check("rst_done_t",    64'(done_t2), 64'h0);
        #2 rst_n = 1'b1;
        step();

        // 200 x 150 unsigned on all three radices, cycle-exact timing
        drive(8'd200, 8'd150, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        launch();
        check("t0_busy2", 64'(busy2), 64'd1);
        check("t0_done2", 64'(done2), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("busy2_k%0d", k), 64'(busy2), 64'(k < 4));
            check($sformatf("done2_k%0d", k), 64'(done2), 64'(k == 4));
            check($sformatf("done1_k%0d", k), 64'(done1), 64'(k == 8));
            check($sformatf("done4_k%0d", k), 64'(done4), 64'(k == 2));
            if (k == 2) check("p4_unsigned", 64'(p4), 64'h7530);
            if (k == 4) begin
                check("p2_unsigned",  64'(p2),  64'h7530);
                check("pt2_unsigned", 64'(pt2), 64'h0);
            end
            if (k == 8) check("p1_unsigned", 64'(p1), 64'h7530);
        end

        // Signed -3 x 5
        drive(8'hFD, 8'h05, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        launch();
        wait_done();
        check("signed_m3x5", 64'(p2), 64'hFFF1);

        // Signed -128 x -128
        drive(8'h80, 8'h80, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        launch();
        wait_done();
        check("signed_80x80", 64'(p2), 64'h4000);

        // Unsigned 255 x 255
        drive(8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        launch();
        wait_done();
        check("unsigned_ffxff", 64'(p2), 64'hFE01);

        // Prefix taint from multiplicand bit 2
        drive(8'd200, 8'd150, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0);
        launch();
        wait_done();
        check("mcand_t_prefix", 64'(pt2),     64'hFFFC);
        check("mcand_t_done_t", 64'(done_t2), 64'h0);

        // Tainted signed_mode poisons the whole product taint
        drive(8'd200, 8'd150, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        launch();
        wait_done();
        check("smode_t_all", 64'(pt2), 64'hFFFF);

        // Tainted start: full product taint and control taints track busy/done
        drive(8'd200, 8'd150, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        launch();
        start_t = 1'b0;
        check("start_t_busy_t", 64'(busy_t2), 64'd1);
        wait_done();
        check("start_t_done_t", 64'(done_t2), 64'd1);
        check("start_t_pt_all", 64'(pt2),     64'hFFFF);
        step();
        check("start_t_done_t_clr", 64'(done_t2), 64'd0);
        check("start_t_busy_t_clr", 64'(busy_t2), 64'd0);

        // start pulsed mid-RUN with new operands is ignored
        drive(8'd200, 8'd150, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        launch();
        step();
        drive(8'd3, 8'd3, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        drive(8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_done();
        check("ignore_product",   64'(p2),      64'h7530);
        check("ignore_product_t", 64'(pt2),     64'h0);
        check("ignore_done_t",    64'(done_t2), 64'h0);
        step();
        check("ignore_no_rerun",  64'(busy2),   64'd0);

        // Back-to-back: start held through the DONE cycle
        drive(8'd200, 8'd150, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        start = 1'b1;
        step();
        drive(8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_done();
        check("b2b_first", 64'(p2), 64'h7530);
        step();
        start = 1'b0;
        check("b2b_busy_again", 64'(busy2), 64'd1);
        check("b2b_hold_prod",  64'(p2),    64'h7530);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("b2b_done_i%0d", i), 64'(done2), 64'(i == 4));
            check($sformatf("b2b_prod_i%0d", i), 64'(p2), (i == 4) ? 64'hFE01 : 64'h7530);
        end

        // Asynchronous reset during RUN cycle 2
        drive(8'd200, 8'd150, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1);
        launch();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_product",   64'(p2),      64'h0);
        check("mid_rst_product_t", 64'(pt2),     64'h0);
        check("mid_rst_busy",      64'(busy2),   64'h0);
        check("mid_rst_busy_t",    64'(busy_t2), 64'h0);
        check("mid_rst_done",      64'(done2),   64'h0);
        #2 rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            saw_done = saw_done | done2;
        end
        check("mid_rst_no_done", 64'(saw_done), 64'd0);
        check("mid_rst_hold",    64'(p2),       64'h0);
        drive(8'hFD, 8'h05, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        launch();
        wait_done();
        check("post_rst_product", 64'(p2),  64'hFFF1);
        check("post_rst_prod_t",  64'(pt2), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier_radix_taint.md
# multiplier_radix_taint

Parametrised, constant-time sequential shift-add multiplier with conservative bitwise taint tracking. It is the successor to the single-bit-per-cycle unsigned taint-tracked multiplier and adds three things: a configurable radix (BITS_PER_CYCLE operand bits retired per cycle), a run-time signed/unsigned mode, and an explicit busy/done handshake. It sits in the information-flow test harness as a drop-in arithmetic unit. Latency depends only on parameters, never on operand values.

## Interface
- WIDTH, 32: operand width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 2: multiplier bits consumed per RUN cycle; legal values are 1, 2, 4.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start, start_t  in  1  request to multiply, and its taint.
- signed_mode, signed_mode_t  in  1  1 selects two's-complement operands; its taint.
- multiplier, multiplier_t  in  WIDTH  operand A and its taint.
- multiplicand, multiplicand_t  in  WIDTH  operand B and its taint.
- product, product_t  out  2*WIDTH  last completed result and its taint.
- busy, busy_t  out  1  high while a multiplication is in progress; its taint.
- done, done_t  out  1  one-cycle completion pulse; its taint.

## Operation
- CYCLES = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE: start=1 accepted, goes to RUN.
  - RUN: counter decrements each edge; at 0 goes to DONE.
  - DONE: start=1 accepted and goes to RUN; otherwise goes to IDLE.
- Acceptance: start is sampled only in IDLE or DONE. In RUN it is ignored and has no effect on any output.
- On accept, the block captures both operands, signed_mode, all input taints, and start_t.
- Arithmetic: product is the exact WIDTH×WIDTH product modulo 2^(2*WIDTH).
  - Unsigned when signed_mode=1'b0.
  - Two's-complement when signed_mode=1'b1: multiplicand is sign-extended, and the final multiplier digit carries negative MSB weight.
- Taint rule, computed from captured values:
  - product_t[i] = |multiplier_t[min(i,WIDTH-1):0] | |multiplicand_t[min(i,WIDTH-1):0].
  - If captured signed_mode_t or start_t is 1, product_t is all ones.
- Control taint: busy_t and done_t equal the captured start_t while busy and done respectively are high; otherwise they are 0.
- Reset values: state IDLE, product=0, product_t=0, busy=0, busy_t=0, done=0, done_t=0, counter=0, internal accumulator=0.
- Reset mid-RUN returns immediately to IDLE. No done pulse is produced and product keeps its reset value of 0.

## Timing
- Edge t0 samples start in IDLE or DONE. busy is high from after t0 until after edge t0+CYCLES.
- product and product_t update only at edge t0+CYCLES. They are stable at all other times, including during a following RUN.
- done is high for exactly the cycle after edge t0+CYCLES.
- Back-to-back: start held high in the DONE cycle is accepted at that edge. Steady-state throughput is one result per CYCLES+1 cycles.
- No combinational path exists from any input to any output.

## Structure
- Package multiplier_taint_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - function cycles(WIDTH, BITS_PER_CYCLE);
  - counter width $clog2(CYCLES+1);
  - function prefix_or_taint(a_t, b_t) returning the 2*WIDTH product_t mask.
- One sub-module is natural: multiplier_radix_control_taint, containing the FSM, counter, busy/done and their taints. The datapath (accumulator, shift registers, digit partial product, taint capture) stays in the top module.
- Parameter legality is checked at elaboration with $error.

## Test plan
- WIDTH=8, BPC=2, unsigned, 200×150, no taint:
  - product=16'h7530 and done pulses one cycle, following edge t0+4.
  - busy is high for the 4 cycles following t0; product_t=0.
- Signed, multiplier=8'hFD (−3), multiplicand=8'h05 → product=16'hFFF1.
- Signed, 8'h80×8'h80 → 16'h4000.
- Unsigned, 8'hFF×8'hFF → 16'hFE01.
- multiplicand_t=8'h04, all other taints 0 → product_t=16'hFFFC, done_t=0.
- signed_mode_t=1 → product_t=16'hFFFF. Separately, start_t=1 → product_t=16'hFFFF, and busy_t and done_t follow busy and done.
- start pulsed again during RUN with new operands → ignored; the first result completes unchanged.
- start held high in the DONE cycle → second result appears 5 cycles after the first done.
- rst_n low at RUN cycle 2 → all outputs 0 immediately, no done; a fresh start afterwards completes normally.
- Repeat the unsigned case with BPC=1 and BPC=4 → done follows edge t0+8 and t0+2 respectively, with identical product.
